// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared state, error and base encodings for the Smith-Waterman array controller
package sw_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, DONE} sw_state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_GAP     = 2'b01,
    ERR_TIMEOUT = 2'b10
  } sw_err_t;

  typedef enum logic [1:0] {
    _T = 2'b00,
    _C = 2'b01,
    _A = 2'b10,
    _G = 2'b11
  } sw_base_t;

  // Mid-scale offset the array adds to every score so it can stay unsigned internally.
  function automatic int unsigned bias(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sw_array_controller_if.sv
// rtl/sw_array_controller_if.sv - target stream and result handshake bundle for sw_array_controller
interface sw_array_controller_if #(
  parameter int SCORE_WIDTH = 12,
  parameter int TLEN_W      = 16
);
  logic                   t_valid;
  logic                   t_ready;
  logic [1:0]             t_base;
  logic                   t_last;
  logic                   res_valid;
  logic                   res_ready;
  logic [SCORE_WIDTH-1:0] res_score;
  logic [TLEN_W-1:0]      res_tlen;
  logic [1:0]             res_err;

  modport master (
    output t_valid, t_base, t_last, res_ready,
    input  t_ready, res_valid, res_score, res_tlen, res_err
  );

  modport slave (
    input  t_valid, t_base, t_last, res_ready,
    output t_ready, res_valid, res_score, res_tlen, res_err
  );
endinterface

// File: rtl/sw_ctrl_watchdog.sv
// rtl/sw_ctrl_watchdog.sv - loadable up-counter; tc marks the last of LIMIT enabled cycles
module sw_ctrl_watchdog #(
  parameter int LIMIT = 136
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CW'(LIMIT - 1));
endmodule

// File: rtl/sw_array_controller.sv
// rtl/sw_array_controller.sv - job sequencer for the Smith-Waterman systolic array
// Optional SW_HIT_FILTER_EN adds cfg_thresh/res_hit score threshold filtering.
module sw_array_controller
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = 12,
  parameter int LENGTH      = 128,
  parameter int LOG_LENGTH  = $clog2(LENGTH),
  parameter int TLEN_W      = 16,
  parameter int DRAIN_MAX   = LENGTH + 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LOG_LENGTH-1:0]  cfg_qlen,
`ifdef SW_HIT_FILTER_EN
  input  logic [SCORE_WIDTH-1:0] cfg_thresh,
  output logic                   res_hit,
`endif
  sw_array_controller_if.slave   bus,
  output logic                   arr_rst_n,
  output logic                   arr_en,
  output logic [1:0]             arr_data,
  output logic [LOG_LENGTH-1:0]  arr_sel,
  input  logic                   arr_vld,
  input  logic [SCORE_WIDTH-1:0] arr_result,
  output logic                   busy
);
  localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(bias(SCORE_WIDTH));

  sw_state_t              state;
  sw_err_t                err_q;
  logic                   clr_phase;
  logic                   got_beat;
  logic                   t_ready_q;
  logic                   res_valid_q;
  logic [SCORE_WIDTH-1:0] score_q;
  logic [TLEN_W-1:0]      tlen_q;
  logic [SCORE_WIDTH-1:0] score_unb;
  logic                   accept;
  logic                   wd_tc;
`ifdef SW_HIT_FILTER_EN
  logic [SCORE_WIDTH-1:0] thresh_q;
`endif

  assign accept    = bus.t_valid && t_ready_q;
  assign score_unb = arr_result - ZERO;

  sw_ctrl_watchdog #(.LIMIT(DRAIN_MAX)) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .load (state != DRAIN),
    .en   (state == DRAIN),
    .tc   (wd_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      err_q       <= ERR_OK;
      clr_phase   <= 1'b0;
      got_beat    <= 1'b0;
      t_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      score_q     <= '0;
      tlen_q      <= '0;
      arr_rst_n   <= 1'b0;
      arr_en      <= 1'b0;
      arr_data    <= _T;
      arr_sel     <= '0;
      busy        <= 1'b0;
`ifdef SW_HIT_FILTER_EN
      thresh_q    <= '0;
      res_hit     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          arr_rst_n <= 1'b1;
          if (start) begin
            state     <= CLEAR;
            arr_rst_n <= 1'b0;
            arr_sel   <= cfg_qlen;
            busy      <= 1'b1;
            clr_phase <= 1'b0;
            got_beat  <= 1'b0;
            tlen_q    <= '0;
            err_q     <= ERR_OK;
`ifdef SW_HIT_FILTER_EN
            thresh_q  <= cfg_thresh;
            res_hit   <= 1'b0;
`endif
          end
        end
        CLEAR: begin
          if (clr_phase) begin
            state     <= LOAD;
            arr_rst_n <= 1'b1;
            t_ready_q <= 1'b1;
          end else begin
            clr_phase <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            arr_en   <= 1'b1;
            arr_data <= bus.t_base;
            got_beat <= 1'b1;
            if (tlen_q != '1) tlen_q <= tlen_q + 1'b1;
            if (bus.t_last) begin
              state     <= DRAIN;
              t_ready_q <= 1'b0;
            end
          end else begin
            // The array reads en low as end-of-target, so a mid-stream gap truncates the job.
            arr_en <= 1'b0;
            if (got_beat) begin
              state     <= DRAIN;
              t_ready_q <= 1'b0;
              err_q     <= ERR_GAP;
            end
          end
        end
        DRAIN: begin
          arr_en <= 1'b0;
          if (arr_vld) begin
            score_q     <= score_unb;
            res_valid_q <= 1'b1;
            state       <= DONE;
`ifdef SW_HIT_FILTER_EN
            res_hit     <= (err_q == ERR_OK) && ($signed(score_unb) >= $signed(thresh_q));
`endif
          end else if (wd_tc) begin
            score_q     <= '0;
            err_q       <= ERR_TIMEOUT;
            res_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.t_ready   = t_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_score = score_q;
  assign bus.res_tlen  = tlen_q;
  assign bus.res_err   = err_q;
endmodule

// File: tb/tb_sw_array_controller.sv
// tb/tb_sw_array_controller.sv - self-checking bench for sw_array_controller (table jobs plus random jobs)
module tb_sw_array_controller;
  localparam int SW   = 12;
  localparam int LEN  = 128;
  localparam int LOGL = 7;
  localparam int TW   = 5;
  localparam int DMAX = LEN + 8;
  localparam int TMAX = (1 << TW) - 1;

  typedef struct {
    int          qlen;
    int          nb;
    bit          gap;
    int          d;
    logic [11:0] ar;
    logic [11:0] th;
    logic [11:0] sc;
    logic [1:0]  er;
    int          tl;
    bit          hit;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [LOGL-1:0] cfg_qlen = '0;
  logic            arr_rst_n;
  logic            arr_en;
  logic [1:0]      arr_data;
  logic [LOGL-1:0] arr_sel;
  logic            arr_vld = 1'b0;
  logic [SW-1:0]   arr_result = '0;
  logic            busy;
`ifdef SW_HIT_FILTER_EN
  logic [SW-1:0]   cfg_thresh = '0;
  logic            res_hit;
`endif

  sw_array_controller_if #(.SCORE_WIDTH(SW), .TLEN_W(TW)) bus ();

  sw_array_controller #(.SCORE_WIDTH(SW), .LENGTH(LEN), .TLEN_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_qlen   (cfg_qlen),
`ifdef SW_HIT_FILTER_EN
    .cfg_thresh (cfg_thresh),
    .res_hit    (res_hit),
`endif
    .bus        (bus),
    .arr_rst_n  (arr_rst_n),
    .arr_en     (arr_en),
    .arr_data   (arr_data),
    .arr_sel    (arr_sel),
    .arr_vld    (arr_vld),
    .arr_result (arr_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  int              mon_en = 0;
  int              mon_rstlo = 0;
  int              mon_drain = 0;
  int              mon_selbad = 0;
  logic [1:0]      data_q[$];
  logic [LOGL-1:0] sel_exp = '0;

  always @(negedge clk) begin
    if (arr_en) begin
      mon_en++;
      data_q.push_back(arr_data);
    end
    if (busy && !arr_rst_n) mon_rstlo++;
    if (busy && !bus.t_ready && arr_rst_n && !bus.res_valid) mon_drain++;
    if (busy && arr_sel !== sel_exp) mon_selbad++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected job outcome computed directly from the scoring rules.
  function automatic vec_t model(input int qlen, input int nb, input bit gap, input int d,
                                 input logic [11:0] ar, input logic [11:0] th);
    vec_t v;
    int   s;
    v.qlen = qlen; v.nb = nb; v.gap = gap; v.d = d; v.ar = ar; v.th = th;
    s    = int'(ar) - 2048;
    v.tl = (nb > TMAX) ? TMAX : nb;
    if (d < 0) begin
      v.sc = 12'h000; v.er = 2'b10; v.hit = 1'b0;
    end else begin
      v.sc  = 12'(s);
      v.er  = gap ? 2'b01 : 2'b00;
      v.hit = !gap && (s >= int'($signed(th)));
    end
    return v;
  endfunction

  task automatic run_job(input vec_t v, input int pre_idle, input int rd);
    int         b_en, b_rst, b_drain, b_sel, b_idx, n, exp_drain;
    logic [1:0] bases[$];
    logic [11:0] sc0;
    logic [TW-1:0] tl0;
    logic [1:0] er0;
    bit         stable, dbad;
    b_en = mon_en; b_rst = mon_rstlo; b_drain = mon_drain; b_sel = mon_selbad;
    b_idx = data_q.size();
    sel_exp  = LOGL'(v.qlen);
    cfg_qlen = LOGL'(v.qlen);
`ifdef SW_HIT_FILTER_EN
    cfg_thresh = v.th;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!bus.t_ready && n < 10) begin @(negedge clk); n++; end
    chk("t_ready_rise", {31'b0, bus.t_ready}, 32'd1);
    repeat (pre_idle) @(negedge clk);
    for (int i = 0; i < v.nb; i++) begin
      bus.t_valid = 1'b1;
      bus.t_base  = 2'($urandom);
      bases.push_back(bus.t_base);
      bus.t_last  = (i == v.nb - 1) && !v.gap;
      @(negedge clk);
    end
    bus.t_valid = 1'b0;
    bus.t_last  = 1'b0;
    if (v.d >= 0) begin
      repeat (v.d) @(negedge clk);
      arr_result = v.ar;
      arr_vld    = 1'b1;
    end
    n = 0;
    while (!bus.res_valid && n < DMAX + 40) begin @(negedge clk); n++; end
    arr_vld = 1'b0;

    chk("res_valid", {31'b0, bus.res_valid}, 32'd1);
    chk("res_score", bus.res_score, v.sc);
    chk("res_tlen", bus.res_tlen, v.tl);
    chk("res_err", bus.res_err, v.er);
`ifdef SW_HIT_FILTER_EN
    chk("res_hit", {31'b0, res_hit}, {31'b0, v.hit});
`endif
    chk("arr_sel", arr_sel, v.qlen);
    chk("sel_stable", mon_selbad - b_sel, 0);
    chk("clear_cycles", mon_rstlo - b_rst, 2);
    chk("en_cycles", mon_en - b_en, v.nb);
    if (v.d < 0) exp_drain = DMAX;
    else if (v.gap) exp_drain = (v.d < 1) ? 1 : v.d;
    else exp_drain = v.d + 1;
    chk("drain_cycles", mon_drain - b_drain, exp_drain);
    dbad = 1'b0;
    for (int i = 0; i < v.nb; i++) begin
      if (data_q.size() <= b_idx + i || data_q[b_idx + i] !== bases[i]) dbad = 1'b1;
    end
    chk("arr_data_seq", {31'b0, dbad}, 32'd0);

    sc0 = bus.res_score; tl0 = bus.res_tlen; er0 = bus.res_err;
    stable = 1'b1;
    for (int i = 0; i < rd; i++) begin
      start = (i == 0);
      @(negedge clk);
      start = 1'b0;
      if (!bus.res_valid || !busy || bus.res_score !== sc0 || bus.res_tlen !== tl0 || bus.res_err !== er0)
        stable = 1'b0;
    end
    chk("res_stable", {31'b0, stable}, 32'd1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("idle_after_ready", {30'b0, busy, bus.res_valid}, 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    #600000;
    $display("FAIL global_timeout: time %0t reached, required finish before it", $time);
    $fatal(1, "bench did not terminate");
  end

  initial begin
    vec_t v;
    bit   seen;
    tbl[0] = '{3,   5,  1'b0,  4, 12'h80A, 12'h000, 12'h00A, 2'b00,  5, 1'b1};
    tbl[1] = '{7,   3,  1'b1,  2, 12'h800, 12'h000, 12'h000, 2'b01,  3, 1'b0};
    tbl[2] = '{0,   4,  1'b0, -1, 12'h123, 12'h000, 12'h000, 2'b10,  4, 1'b0};
    tbl[3] = '{1,   2,  1'b0,  1, 12'h7FE, 12'h005, 12'hFFE, 2'b00,  2, 1'b0};
    tbl[4] = '{1,   2,  1'b0,  1, 12'h805, 12'h005, 12'h005, 2'b00,  2, 1'b1};
    tbl[5] = '{127, 35, 1'b0,  3, 12'hFFF, 12'h000, 12'h7FF, 2'b00, 31, 1'b1};
    tbl[6] = '{5,   2,  1'b1, -1, 12'h000, 12'h000, 12'h000, 2'b10,  2, 1'b0};
    tbl[7] = '{64,  1,  1'b0,  0, 12'h000, 12'h800, 12'h800, 2'b00,  1, 1'b1};

    bus.t_valid = 1'b1;
    bus.t_base = 2'b00;
    bus.t_last = 1'b0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_t_ready", {31'b0, bus.t_ready}, 32'd0);
    chk("rst_arr_rst_n", {31'b0, arr_rst_n}, 32'd0);
    chk("rst_arr_en", {31'b0, arr_en}, 32'd0);
    chk("rst_arr_data", arr_data, 32'd0);
    chk("rst_arr_sel", arr_sel, 32'd0);
    chk("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("rst_res_score", bus.res_score, 32'd0);
    chk("rst_res_tlen", bus.res_tlen, 32'd0);
    chk("rst_res_err", bus.res_err, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
`ifdef SW_HIT_FILTER_EN
    chk("rst_res_hit", {31'b0, res_hit}, 32'd0);
`endif
    rst = 1'b0;
    bus.t_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_job(tbl[i], i % 3, (i == 0) ? 10 : i % 3);

    // Abort mid-LOAD: reset must kill the job without ever presenting a result.
    cfg_qlen = 7'd5;
    sel_exp  = 7'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    bus.t_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_t_ready", {31'b0, bus.t_ready}, 32'd0);
    chk("abort_arr_rst_n", {31'b0, arr_rst_n}, 32'd0);
    chk("abort_arr_en", {31'b0, arr_en}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_arr_sel", arr_sel, 32'd0);
    rst = 1'b0;
    bus.t_valid = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.res_valid || busy) seen = 1'b1;
    end
    chk("abort_no_result", {31'b0, seen}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      int d;
      d = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 20));
      v = model(int'($urandom_range(0, 127)), int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)),
                d, 12'($urandom), 12'($urandom));
      run_job(v, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
